accum_feeder: RTL and testbench

//   Producer side of the accumulator stream (data/ivalid/first/last) in the MVM engine.

---
 rtl/accum_feeder.sv | 185 ++++++++++++++++++
 tb/tb_accum_feeder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_feeder.sv
// accum_feeder: producer side of the accumulator stream in the MVM engine.
// Walks a matrix stored as LANES-wide row chunks, reads the matching vector chunk,
// and emits one signed LANES-element dot product per chunk as a tagged beat.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               launch a job (sampled only while idle)
//   num_rows, num_cols  job dimensions (rows, LANES-wide chunks per row), latched on start
//   mat_raddr/mat_rdata matrix memory read port (MEM_LAT cycle latency)
//   vec_raddr/vec_rdata vector memory read port (MEM_LAT cycle latency)
//   data, ovalid        signed dot-product beat and its valid
//   first, last         beat is the first / last chunk of its row
//   busy, done          job in progress / one-cycle job-complete pulse
module accum_feeder #(
  parameter int unsigned DATAW   = 8,
  parameter int unsigned LANES   = 4,
  parameter int unsigned ADDRW   = 9,
  parameter int unsigned MEM_LAT = 1,
  localparam int unsigned OUTW   = 2 * DATAW + $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRW-1:0]       num_rows,
  input  logic [ADDRW-1:0]       num_cols,
  output logic [ADDRW-1:0]       mat_raddr,
  input  logic [LANES*DATAW-1:0] mat_rdata,
  output logic [ADDRW-1:0]       vec_raddr,
  input  logic [LANES*DATAW-1:0] vec_rdata,
  output logic [OUTW-1:0]        data,
  output logic                   ovalid,
  output logic                   first,
  output logic                   last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned ProdW  = 2 * DATAW;
  localparam int unsigned ExtW   = OUTW - ProdW;
  localparam int unsigned DrainW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q;
  logic [ADDRW-1:0]    rows_q, cols_q;
  logic [ADDRW-1:0]    row_q, col_q;
  logic [ADDRW-1:0]    mat_addr_q;
  logic [DrainW-1:0]   drain_q;
  logic                busy_q, done_q;

  // Tags for reads in flight; stage MEM_LAT-1 lines up with the returning rdata.
  logic [MEM_LAT-1:0]  tag_v_q, tag_f_q, tag_l_q;

  logic                issue;
  logic                issue_first, issue_last;
  logic                row_end, job_end;

  logic [OUTW-1:0]     data_q;
  logic                ovalid_q, first_q, last_q;

  assign issue       = (state_q == StRun);
  assign row_end     = (col_q == cols_q - ADDRW'(1));
  assign job_end     = row_end && (row_q == rows_q - ADDRW'(1));
  assign issue_first = (col_q == '0);
  assign issue_last  = row_end;

  // Control FSM and address generation. The matrix address is a plain running
  // counter; row-major chunk order makes it equal to r*num_cols+c without a multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      mat_addr_q <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            rows_q     <= num_rows;
            cols_q     <= num_cols;
            row_q      <= '0;
            col_q      <= '0;
            mat_addr_q <= '0;
            busy_q     <= 1'b1;
            if ((num_rows == '0) || (num_cols == '0)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          mat_addr_q <= mat_addr_q + ADDRW'(1);
          if (row_end) begin
            col_q <= '0;
            row_q <= row_q + ADDRW'(1);
            if (job_end) begin
              state_q <= StDrain;
              drain_q <= '0;
            end
          end else begin
            col_q <= col_q + ADDRW'(1);
          end
        end
        StDrain: begin
          // Covers MEM_LAT read cycles plus the output register stage.
          if (drain_q == DrainW'(MEM_LAT)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DrainW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mat_raddr = mat_addr_q;
  assign vec_raddr = col_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Lane products. Operands are sign-extended to ProdW so the product is exact.
  logic [ProdW-1:0] prod [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [ProdW-1:0] m_ext, v_ext;
    assign m_ext   = {{DATAW{mat_rdata[g*DATAW+DATAW-1]}}, mat_rdata[g*DATAW +: DATAW]};
    assign v_ext   = {{DATAW{vec_rdata[g*DATAW+DATAW-1]}}, vec_rdata[g*DATAW +: DATAW]};
    assign prod[g] = m_ext * v_ext;
  end

  logic [OUTW-1:0] dot;

  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + {{ExtW{prod[i][ProdW-1]}}, prod[i]};
    end
  end

  // Tag pipeline and output register. Idle beats force data/first/last to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q  <= '0;
      tag_f_q  <= '0;
      tag_l_q  <= '0;
      data_q   <= '0;
      ovalid_q <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      tag_v_q[0] <= issue;
      tag_f_q[0] <= issue && issue_first;
      tag_l_q[0] <= issue && issue_last;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_f_q[i] <= tag_f_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end
      ovalid_q <= tag_v_q[MEM_LAT-1];
      first_q  <= tag_v_q[MEM_LAT-1] && tag_f_q[MEM_LAT-1];
      last_q   <= tag_v_q[MEM_LAT-1] && tag_l_q[MEM_LAT-1];
      data_q   <= tag_v_q[MEM_LAT-1] ? dot : '0;
    end
  end

  assign data   = data_q;
  assign ovalid = ovalid_q;
  assign first  = first_q;
  assign last   = last_q;

endmodule

// File: tb/tb_accum_feeder.sv
// Scoreboard bench for accum_feeder: one instance at MEM_LAT=1, one at MEM_LAT=3,
// sharing behavioural matrix/vector memories.
module tb_accum_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, start3 = 1'b0;
  logic [8:0]  num_rows = '0, num_cols = '0;
  logic [8:0]  mat_raddr1, vec_raddr1, mat_raddr3, vec_raddr3;
  logic [31:0] mat_rdata1, vec_rdata1, mat_rdata3, vec_rdata3;
  logic [17:0] data1, data3;
  logic        ovalid1, first1, last1, busy1, done1;
  logic        ovalid3, first3, last3, busy3, done3;

  logic [31:0] mat_mem [512];
  logic [31:0] vec_mem [512];
  logic [31:0] mp3 [3];
  logic [31:0] vp3 [3];

  always @(posedge clk) begin
    mat_rdata1 <= mat_mem[mat_raddr1];
    vec_rdata1 <= vec_mem[vec_raddr1];
    mp3[0] <= mat_mem[mat_raddr3];
    vp3[0] <= vec_mem[vec_raddr3];
    mp3[1] <= mp3[0];
    vp3[1] <= vp3[0];
    mp3[2] <= mp3[1];
    vp3[2] <= vp3[1];
  end
  assign mat_rdata3 = mp3[2];
  assign vec_rdata3 = vp3[2];

  accum_feeder #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .num_rows(num_rows), .num_cols(num_cols),
    .mat_raddr(mat_raddr1), .mat_rdata(mat_rdata1), .vec_raddr(vec_raddr1),
    .vec_rdata(vec_rdata1), .data(data1), .ovalid(ovalid1), .first(first1), .last(last1),
    .busy(busy1), .done(done1)
  );

  accum_feeder #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .num_rows(num_rows), .num_cols(num_cols),
    .mat_raddr(mat_raddr3), .mat_rdata(mat_rdata3), .vec_raddr(vec_raddr3),
    .vec_rdata(vec_rdata3), .data(data3), .ovalid(ovalid3), .first(first3), .last(last3),
    .busy(busy3), .done(done3)
  );

  typedef struct packed {
    logic [17:0] data;
    logic        first;
    logic        last;
  } beat_t;

  beat_t q1[$];
  beat_t q3[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;
  int    beats [2];
  int    first_cyc [2];
  int    last_cyc [2];
  bit    mon_en = 1'b0;
  bit    sel = 1'b0;

  logic [8:0] mat_raddr_s, vec_raddr_s;
  logic       busy_s, done_s;
  assign mat_raddr_s = sel ? mat_raddr3 : mat_raddr1;
  assign vec_raddr_s = sel ? vec_raddr3 : vec_raddr1;
  assign busy_s      = sel ? busy3 : busy1;
  assign done_s      = sel ? done3 : done1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Monitor side of the scoreboard.
  task automatic check_beat(input int idx, input logic ov, input logic [17:0] d,
                            input logic f, input logic l);
    beat_t e;
    compared++;
    if (ov) begin
      if ((idx == 0 && q1.size() == 0) || (idx == 1 && q3.size() == 0)) begin
        mismatched++;
        $display("FAIL unexpected_beat dut%0d: got data=%0d first=%0b last=%0b, required no beat",
                 idx, $signed(d), f, l);
      end else begin
        if (idx == 0) e = q1.pop_front();
        else          e = q3.pop_front();
        if ({d, f, l} !== {e.data, e.first, e.last}) begin
          mismatched++;
          $display("FAIL beat dut%0d: got data=%0d first=%0b last=%0b, required data=%0d first=%0b last=%0b",
                   idx, $signed(d), f, l, $signed(e.data), e.first, e.last);
        end
      end
      beats[idx]++;
      if (first_cyc[idx] < 0) first_cyc[idx] = cyc;
      last_cyc[idx] = cyc;
    end else if ({d, f, l} !== '0) begin
      mismatched++;
      $display("FAIL idle_zero dut%0d: got data=%0d first=%0b last=%0b, required all 0",
               idx, $signed(d), f, l);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_beat(0, ovalid1, data1, first1, last1);
      check_beat(1, ovalid3, data3, first3, last3);
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input bit idx, input int d, input bit f, input bit l);
    beat_t b;
    b.data  = 18'(d);
    b.first = f;
    b.last  = l;
    if (idx) q3.push_back(b);
    else     q1.push_back(b);
  endtask

  task automatic set_start(input logic v);
    if (sel) start3 = v;
    else     start1 = v;
  endtask

  task automatic fill(input bit is_vec, input int base, input int n,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    for (int i = base; i < base + n; i++) begin
      if (is_vec) vec_mem[i] = {b3, b2, b1, b0};
      else        mat_mem[i] = {b3, b2, b1, b0};
    end
  endtask

  // Runs one job on the selected instance; expected beats must already be queued.
  task automatic run_job(input int rows, input int cols, input bit poke);
    int n, lat, done_k, exp_done, issue0, qleft;
    n      = rows * cols;
    lat    = sel ? 3 : 1;
    done_k = -1;
    beats[sel]     = 0;
    first_cyc[sel] = -1;
    num_rows = 9'(rows);
    num_cols = 9'(cols);
    set_start(1'b1);
    tick;
    set_start(1'b0);
    check("busy_after_start", busy_s, 1);
    issue0 = cyc;
    for (int k = 0; k < 400; k++) begin
      if (k < n) begin
        check("mat_raddr", mat_raddr_s, k);
        check("vec_raddr", vec_raddr_s, k % cols);
      end
      if (done_s) begin
        done_k = k;
        break;
      end
      if (poke && k == 2) begin
        num_rows = 9'd5;
        num_cols = 9'd5;
        set_start(1'b1);
      end else if (poke && k == 3) begin
        set_start(1'b0);
      end
      tick;
    end
    exp_done = (n == 0) ? 0 : n + lat + 1;
    check("done_cycle", done_k, exp_done);
    if (n > 0) begin
      check("first_beat_latency", first_cyc[sel] - issue0, lat + 1);
      check("done_after_last_beat", cyc - last_cyc[sel], 1);
    end
    tick;
    check("done_one_cycle", done_s, 0);
    check("busy_back_idle", busy_s, 0);
    check("beat_count", beats[sel], n);
    qleft = sel ? q3.size() : q1.size();
    check("queue_drained", qleft, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mat_mem[i] = '0;
      vec_mem[i] = '0;
    end
    beats     = '{0, 0};
    first_cyc = '{-1, -1};
    last_cyc  = '{0, 0};
    repeat (3) tick;
    check("reset_ovalid", ovalid1, 0);
    check("reset_data", data1, 0);
    check("reset_busy", busy1, 0);
    check("reset_done", done1, 0);
    check("reset_mat_raddr", mat_raddr1, 0);
    check("reset_busy3", busy3, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick;

    // 2x3 of all ones: 4 per beat, first on chunk 0, last on chunk 2.
    sel = 1'b0;
    fill(0, 0, 6, 8'd1, 8'd1, 8'd1, 8'd1);
    fill(1, 0, 4, 8'd1, 8'd1, 8'd1, 8'd1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) push(0, 4, c == 0, c == 2);
    run_job(2, 3, 0);

    // Signed extremes: (-128)*(-128)*4 = 65536, (-128)*127*4 = -65024.
    fill(0, 0, 1, 8'h80, 8'h80, 8'h80, 8'h80);
    fill(1, 0, 1, 8'h80, 8'h80, 8'h80, 8'h80);
    push(0, 65536, 1, 1);
    run_job(1, 1, 0);
    fill(1, 0, 1, 8'h7f, 8'h7f, 8'h7f, 8'h7f);
    push(0, -65024, 1, 1);
    run_job(1, 1, 0);

    // Mixed signs per lane: 1*5 + (-2)*6 + 3*(-7) + (-4)*8 = -60.
    fill(0, 0, 1, 8'd1, 8'hfe, 8'd3, 8'hfc);
    fill(1, 0, 1, 8'd5, 8'd6, 8'hf9, 8'd8);
    push(0, -60, 1, 1);
    run_job(1, 1, 0);

    // Single-chunk rows: row k holds k+1 in every lane, vector all ones.
    fill(0, 0, 1, 8'd1, 8'd1, 8'd1, 8'd1);
    fill(0, 1, 1, 8'd2, 8'd2, 8'd2, 8'd2);
    fill(0, 2, 1, 8'd3, 8'd3, 8'd3, 8'd3);
    fill(1, 0, 1, 8'd1, 8'd1, 8'd1, 8'd1);
    push(0, 4, 1, 1);
    push(0, 8, 1, 1);
    push(0, 12, 1, 1);
    run_job(3, 1, 0);

    // Empty job: immediate done, no beats.
    run_job(0, 5, 0);

    // start with new dims while running must not disturb the job.
    fill(0, 0, 8, 8'd1, 8'd1, 8'd1, 8'd1);
    fill(1, 0, 4, 8'd1, 8'd1, 8'd1, 8'd1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) push(0, 4, c == 0, c == 2);
    run_job(2, 3, 1);

    // Reset after 2 of 4 beats, then a fresh 1x2 job.
    for (int c = 0; c < 4; c++) push(0, 4, c == 0, c == 3);
    beats[0] = 0;
    num_rows = 9'd1;
    num_cols = 9'd4;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    begin : wait_two
      int k;
      for (k = 0; k < 50; k++) begin
        if (beats[0] >= 2) break;
        tick;
      end
      check("beats_before_reset", beats[0], 2);
    end
    rst = 1'b1;
    q1.delete();
    tick;
    rst = 1'b0;
    check("abort_ovalid", ovalid1, 0);
    check("abort_busy", busy1, 0);
    repeat (6) tick;
    check("no_stale_beats", beats[0], 2);
    push(0, 4, 1, 0);
    push(0, 4, 0, 1);
    run_job(1, 2, 0);

    // MEM_LAT=3 instance: same data as the first job, deeper latency.
    sel = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) push(1, 4, c == 0, c == 2);
    run_job(2, 3, 0);

    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
